// File: rtl/cpu_feeder_pkg.sv
// cpu_feeder_pkg: shared state encoding and program byte layout for the instruction feeder
package cpu_feeder_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_EXEC, SETTLE, DONE} state_t;
  localparam logic [3:0] HALT_OP = 4'hF;
  localparam int OP_LSB = 0;
  localparam int OP_MSB = 3;
  localparam int DATA_LSB = 4;
  localparam int DATA_MSB = 7;
  function automatic logic [3:0] byte_op(input logic [7:0] b);
    return b[OP_MSB:OP_LSB];
  endfunction
  function automatic logic [3:0] byte_data(input logic [7:0] b);
    return b[DATA_MSB:DATA_LSB];
  endfunction
endpackage

// File: rtl/prog_buffer.sv
// prog_buffer: DEPTH x 8 program store, synchronous write, asynchronous read, zeroed on reset
module prog_buffer #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  assign rdata = mem[raddr];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
endmodule

// File: rtl/cpu_prog_feeder.sv
// cpu_prog_feeder: buffers program bytes and replays them one step at a time into the accumulator CPU
module cpu_prog_feeder
  import cpu_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TIMEOUT_CYC = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_byte,
  input  logic          clear,
  input  logic          start,
  input  logic          abort,
  input  logic          cpu_exec,
  input  logic          cpu_halt,
  output logic [7:0]    instr_out,
  output logic          load_instr,
  output logic          step,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] count,
  output logic [CW-1:0] issued
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  state_t state;
  logic [CW-1:0] ptr;
  logic [TW-1:0] tmo;
  logic [7:0] rdata;
  logic [AW-1:0] raddr;
  assign wr_ready = (state == IDLE || state == DONE) && count < FULL && !clear && !start;
  // start always fetches entry 0; later issues read the already-advanced pointer
  assign raddr = state == SETTLE ? ptr[AW-1:0] : '0;
  prog_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk(clk), .rst(rst), .we(wr_valid && wr_ready), .waddr(count[AW-1:0]),
    .wdata(wr_byte), .raddr(raddr), .rdata(rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      tmo <= '0;
      instr_out <= '0;
      load_instr <= 1'b0;
      step <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      count <= '0;
      issued <= '0;
    end else begin
      if (wr_valid && wr_ready) count <= count + 1'b1;
      if (abort) begin
        state <= IDLE;
        load_instr <= 1'b0;
        step <= 1'b0;
        busy <= 1'b0;
        done <= 1'b0;
        error <= 1'b0;
      end else case (state)
        IDLE, DONE: if (clear) begin
          state <= IDLE;
          count <= '0;
          issued <= '0;
          done <= 1'b0;
          error <= 1'b0;
        end else if (start) begin
          ptr <= '0;
          issued <= '0;
          error <= 1'b0;
          if (count == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            state <= ISSUE;
            instr_out <= rdata;
            load_instr <= 1'b1;
            step <= 1'b1;
            busy <= 1'b1;
            done <= 1'b0;
          end
        end
        ISSUE: begin
          state <= WAIT_EXEC;
          step <= 1'b0;
          tmo <= '0;
        end
        WAIT_EXEC: if (cpu_exec) begin
          state <= SETTLE;
          load_instr <= 1'b0;
          ptr <= ptr + 1'b1;
          issued <= issued + 1'b1;
        end else if (tmo == TMO_LAST) begin
          state <= DONE;
          load_instr <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
          error <= 1'b1;
        end else tmo <= tmo + 1'b1;
        SETTLE: if (cpu_halt || ptr == count) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          state <= ISSUE;
          instr_out <= rdata;
          load_instr <= 1'b1;
          step <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
